// File: rtl/m6809_alu16_seq.sv
// 16-bit operand sequencer for the 6809 ALU: big-endian byte moves over the 8-bit bus, one EXEC cycle, done pulse.
// Latency 4 cycles (2 for REG) plus one per bus wait cycle; stalls on mem_ack, aborts with err after TIMEOUT waits.
module m6809_alu16_seq #(
  parameter int TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  kind,
  input  logic [3:0]  op,
  input  logic        op6,
  input  logic        page2,
  input  logic        page3,
  input  logic [15:0] ea,
  input  logic [15:0] reg_in,
  input  logic [15:0] imm_in,
  input  logic        c_in,
  input  logic        v_in,
  input  logic        h_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_op,
  output logic        alu_op6,
  output logic        alu_page2,
  output logic        alu_page3,
  output logic        alu_cin,
  output logic        alu_vin,
  output logic        alu_hin,
  input  logic [15:0] alu_out,
  input  logic        alu_c,
  input  logic        alu_z,
  input  logic        alu_n,
  input  logic        alu_v,
  input  logic        alu_h,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        wb_en,
  output logic        cc_we,
  output logic        cc_c,
  output logic        cc_z,
  output logic        cc_n,
  output logic        cc_v,
  output logic        cc_h,
  output logic        err
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
  localparam logic [1:0] K_LOAD = 2'd0, K_STORE = 2'd1, K_CMP = 2'd2, K_REG = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_RD_HI, S_RD_LO, S_EXEC, S_WR_HI, S_WR_LO, S_DONE} state_t;
  state_t state;

  logic [1:0]    kind_q;
  logic [3:0]    op_q;
  logic          op6_q, page2_q, page3_q, c_q, v_q, h_q;
  logic [15:0]   ea_q, reg_q, imm_q, opnd_q;
  logic [CW-1:0] wcnt;
  logic [15:0]   ea_nxt;
  logic          bus_st, in_exec, tmo;

  // EA+1 deliberately wraps at the top of the address space
  assign ea_nxt  = ea_q + 16'd1;
  assign bus_st  = state inside {S_RD_HI, S_RD_LO, S_WR_HI, S_WR_LO};
  assign in_exec = (state == S_EXEC);
  assign tmo     = (TIMEOUT != 0) && bus_st && !mem_ack && (wcnt == TMAX);
  assign busy    = (state != S_IDLE);

  // ALU is only driven during EXEC so it sees quiet inputs otherwise
  assign alu_a     = in_exec ? ((kind_q == K_LOAD) ? opnd_q : reg_q) : 16'h0000;
  assign alu_b     = in_exec ? ((kind_q == K_REG) ? imm_q : (kind_q == K_STORE) ? reg_q : opnd_q) : 16'h0000;
  assign alu_op    = in_exec ? op_q : 4'h0;
  assign alu_op6   = in_exec & op6_q;
  assign alu_page2 = in_exec & page2_q;
  assign alu_page3 = in_exec & page3_q;
  assign alu_cin   = in_exec & c_q;
  assign alu_vin   = in_exec & v_q;
  assign alu_hin   = in_exec & h_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      kind_q    <= 2'd0;
      op_q      <= 4'h0;
      op6_q     <= 1'b0;
      page2_q   <= 1'b0;
      page3_q   <= 1'b0;
      c_q       <= 1'b0;
      v_q       <= 1'b0;
      h_q       <= 1'b0;
      ea_q      <= 16'h0000;
      reg_q     <= 16'h0000;
      imm_q     <= 16'h0000;
      opnd_q    <= 16'h0000;
      wcnt      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 8'h00;
      done      <= 1'b0;
      result    <= 16'h0000;
      wb_en     <= 1'b0;
      cc_we     <= 1'b0;
      cc_c      <= 1'b0;
      cc_z      <= 1'b0;
      cc_n      <= 1'b0;
      cc_v      <= 1'b0;
      cc_h      <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (bus_st && !mem_ack) wcnt <= wcnt + CW'(1);
      case (state)
        S_IDLE: begin
          done  <= 1'b0;
          cc_we <= 1'b0;
          wb_en <= 1'b0;
          err   <= 1'b0;
          if (start) begin
            kind_q  <= kind;
            op_q    <= op;
            op6_q   <= op6;
            page2_q <= page2;
            page3_q <= page3;
            c_q     <= c_in;
            v_q     <= v_in;
            h_q     <= h_in;
            ea_q    <= ea;
            reg_q   <= reg_in;
            imm_q   <= imm_in;
            wcnt    <= '0;
            if (kind == K_LOAD || kind == K_CMP) begin
              state    <= S_RD_HI;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= ea;
            end else begin
              state <= S_EXEC;
            end
          end
        end
        S_RD_HI: if (mem_ack) begin
          opnd_q[15:8] <= mem_rdata;
          mem_addr     <= ea_nxt;
          wcnt         <= '0;
          state        <= S_RD_LO;
        end
        S_RD_LO: if (mem_ack) begin
          opnd_q[7:0] <= mem_rdata;
          mem_req     <= 1'b0;
          state       <= S_EXEC;
        end
        S_EXEC: begin
          result <= alu_out;
          cc_c   <= alu_c;
          cc_z   <= alu_z;
          cc_n   <= alu_n;
          cc_v   <= alu_v;
          cc_h   <= alu_h;
          if (kind_q == K_STORE) begin
            state     <= S_WR_HI;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= ea_q;
            mem_wdata <= reg_q[15:8];
            wcnt      <= '0;
          end else begin
            state <= S_DONE;
            done  <= 1'b1;
            cc_we <= 1'b1;
            wb_en <= (kind_q == K_LOAD) || (kind_q == K_REG);
          end
        end
        S_WR_HI: if (mem_ack) begin
          mem_addr  <= ea_nxt;
          mem_wdata <= reg_q[7:0];
          wcnt      <= '0;
          state     <= S_WR_LO;
        end
        S_WR_LO: if (mem_ack) begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          state   <= S_DONE;
          done    <= 1'b1;
          cc_we   <= 1'b1;
          wb_en   <= 1'b0;
        end
        S_DONE: begin
          done  <= 1'b0;
          cc_we <= 1'b0;
          wb_en <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      // Abort overrides the stalled bus state; an ack in the same cycle keeps tmo low
      if (tmo) begin
        err     <= 1'b1;
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        state   <= S_IDLE;
      end
    end
  end
endmodule
